// File: rtl/multi_counter_status_q.sv
// multi_counter_status_q
// Captures query responses from the multi-counter status interface into a
// small FIFO and presents them to a consumer over valid/ready. The upstream
// pipeline cannot stall, so pushes arriving while full (and not covered by a
// same-cycle pop) are dropped and flagged in a sticky overflow bit.
//
// Optional feature macro: MULTI_COUNTER_STATUS_Q_DROP_CNT_EN
//   defined   : drop_cnt_r counts dropped responses, saturating
//   undefined : drop_cnt_r is tied to 0
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_pass, in_qry   status beat valid / beat is a query response
//   in_id, in_dat     counter id / value of the beat
//   out_vld, out_rdy  head valid / consumer accepts head
//   out_id, out_dat   head entry, zero when out_vld=0
//   fill_r            occupancy 0..DEPTH
//   ovfl_r, ovfl_clr  sticky overflow flag / clear for flag and drop count
//   drop_cnt_r        dropped-response count
module multi_counter_status_q #(
    parameter int unsigned CNTRS_N    = 256,
    parameter int unsigned CNTRS_W    = 32,
    parameter int unsigned CNTRS_ID_W = $clog2(CNTRS_N),
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_pass,
    input  logic                       in_qry,
    input  logic [CNTRS_ID_W-1:0]      in_id,
    input  logic [CNTRS_W-1:0]         in_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [CNTRS_ID_W-1:0]      out_id,
    output logic [CNTRS_W-1:0]         out_dat,
    output logic [$clog2(DEPTH):0]     fill_r,
    output logic                       ovfl_r,
    input  logic                       ovfl_clr,
    output logic [DROP_CNT_W-1:0]      drop_cnt_r
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef struct packed {
        logic [CNTRS_ID_W-1:0] id;
        logic [CNTRS_W-1:0]    dat;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                ovfl_q, ovfl_d;

    logic push_c, pop_c, full_c, accept_c, drop_c;
    entry_t head_c;

    // Handshake decode; a pop at full frees the slot for a same-cycle push
    always_comb begin
        push_c   = in_pass & in_qry;
        full_c   = (fill_q == FILL_W'(DEPTH));
        pop_c    = out_vld & out_rdy;
        accept_c = push_c & (~full_c | pop_c);
        drop_c   = push_c & ~accept_c;
    end

    // Next-state for pointers, occupancy and overflow; drop beats clear
    always_comb begin
        wr_d   = wr_q + PTR_W'(accept_c);
        rd_d   = rd_q + PTR_W'(pop_c);
        fill_d = fill_q + FILL_W'(accept_c) - FILL_W'(pop_c);
        ovfl_d = ovfl_q;
        if (ovfl_clr) ovfl_d = 1'b0;
        if (drop_c)   ovfl_d = 1'b1;
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            ovfl_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
            ovfl_q <= ovfl_d;
        end
    end

    // Entry storage; contents are not reset, occupancy alone marks validity
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            mem_q[wr_q].id  <= in_id;
            mem_q[wr_q].dat <= in_dat;
        end
    end

`ifdef MULTI_COUNTER_STATUS_Q_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Saturating drop count; a drop in the clear cycle restarts it at 1
    always_comb begin
        drop_d = drop_q;
        if (ovfl_clr) drop_d = '0;
        if (drop_c) begin
            if (ovfl_clr)                       drop_d = DROP_CNT_W'(1);
            else if (drop_q != {DROP_CNT_W{1'b1}}) drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_cnt_r = drop_q;
`else
    assign drop_cnt_r = '0;
`endif

    // Outputs come only from registered state
    assign head_c  = mem_q[rd_q];
    assign out_vld = (fill_q != '0);
    assign out_id  = out_vld ? head_c.id  : '0;
    assign out_dat = out_vld ? head_c.dat : '0;
    assign fill_r  = fill_q;
    assign ovfl_r  = ovfl_q;

endmodule

// File: tb/tb_multi_counter_status_q.sv
// Testbench for multi_counter_status_q: directed scenarios followed by random
// traffic, checked by a queue-based reference model and a negedge monitor.
module tb_multi_counter_status_q;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned DROP_W  = 16;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_pass, in_qry;
    logic [ID_W-1:0]   in_id;
    logic [DAT_W-1:0]  in_dat;
    logic              out_vld, out_rdy;
    logic [ID_W-1:0]   out_id;
    logic [DAT_W-1:0]  out_dat;
    logic [3:0]        fill_r;
    logic              ovfl_r, ovfl_clr;
    logic [DROP_W-1:0] drop_cnt_r;

    multi_counter_status_q #(
        .CNTRS_N(256), .CNTRS_W(DAT_W), .DEPTH(DEPTH), .DROP_CNT_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_pass(in_pass), .in_qry(in_qry), .in_id(in_id), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_dat(out_dat),
        .fill_r(fill_r), .ovfl_r(ovfl_r), .ovfl_clr(ovfl_clr), .drop_cnt_r(drop_cnt_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [ID_W-1:0]  id;
        bit [DAT_W-1:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   m_fill  = 0;
    bit   m_ovfl  = 0;
    int   m_drop  = 0;
    bit   started = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: an occupancy count plus the queue of expected entries
    always @(posedge clk) begin
        bit push, pop, acc, drop;
        if (rst) begin
            m_fill = 0; m_ovfl = 0; m_drop = 0; started = 1;
            exp_q.delete();
        end else if (started) begin
            push = in_pass && in_qry;
            pop  = (m_fill != 0) && out_rdy;
            acc  = push && (m_fill < DEPTH || pop);
            drop = push && !acc;
            if (acc) exp_q.push_back('{id: in_id, dat: in_dat});
            m_fill = m_fill + int'(acc) - int'(pop);
            if (ovfl_clr) begin m_ovfl = 0; m_drop = 0; end
            if (drop) begin
                m_ovfl = 1;
                if (m_drop < DROP_MAX) m_drop++;
            end
        end
    end

    // Monitor: status every cycle, head compared whenever it is consumed
    always @(negedge clk) begin
        exp_t e;
        int exp_drop;
        if (started) begin
`ifdef MULTI_COUNTER_STATUS_Q_DROP_CNT_EN
            exp_drop = m_drop;
`else
            exp_drop = 0;
`endif
            chk("fill_r",     64'(fill_r),     64'(m_fill));
            chk("out_vld",    64'(out_vld),    64'(m_fill != 0));
            chk("ovfl_r",     64'(ovfl_r),     64'(m_ovfl));
            chk("drop_cnt_r", 64'(drop_cnt_r), 64'(exp_drop));
            if (!out_vld) begin
                chk("out_id_idle",  64'(out_id),  64'(0));
                chk("out_dat_idle", 64'(out_dat), 64'(0));
            end else if (out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pop_empty at %0t: got out_vld=1 expected no entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id",  64'(out_id),  64'(e.id));
                    chk("out_dat", 64'(out_dat), 64'(e.dat));
                end
            end
        end
    end

    task automatic step(input bit p, input bit q, input bit [ID_W-1:0] id,
                        input bit [DAT_W-1:0] d, input bit r, input bit c, input bit rs);
        in_pass = p; in_qry = q; in_id = id; in_dat = d;
        out_rdy = r; ovfl_clr = c; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, r, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Basic pass-through
        step(1, 1, 8'd3, 32'h10, 1, 0, 0);
        step(1, 1, 8'd7, 32'h22, 1, 0, 0);
        idle(1, 3);

        // Filter: status beats without the query flag
        for (int i = 0; i < 5; i++) step(1, 0, 8'(i), 32'(i), 1, 0, 0);
        idle(1, 1);

        // Fill and drop, then drain
        for (int i = 0; i < 10; i++) step(1, 1, 8'(i), 32'(i), 0, 0, 0);
        idle(0, 2);
        idle(1, 10);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(1, 1, 8'(20 + i), 32'h100 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 8'h55, 32'hAA, 1, 0, 0);
        idle(1, 12);

        // Clear precedence: drop in the clear cycle, then clear alone
        for (int i = 0; i < 8; i++) step(1, 1, 8'(40 + i), 32'h200 + 32'(i), 0, 0, 0);
        step(1, 1, 8'hEE, 32'hDEAD, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1, 10);

        // Reset mid-traffic with a push pending
        for (int i = 0; i < 5; i++) step(1, 1, 8'(60 + i), 32'h300 + 32'(i), 0, 0, 0);
        step(1, 1, 8'hFF, 32'hBAD, 0, 0, 1);
        step(1, 1, 8'd9, 32'h99, 0, 0, 0);
        idle(0, 2);
        idle(1, 3);

        // Random traffic with alternating consumer pressure
        for (int i = 0; i < 3000; i++) begin
            bit slow;
            slow = ((i / 200) % 2) == 1;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                 8'($urandom), 32'($urandom),
                 slow ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
        end
        idle(1, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_counter_status_q.md
# multi_counter_status_q

Status capture queue that sits directly downstream of the multi-counter pipeline's status interface. Every query response (pass with query flag set) is captured into a small FIFO and presented to a consumer over a valid/ready handshake. This decouples the counter pipeline, which cannot be stalled, from a consumer that can. Responses arriving while the queue is full are dropped and flagged in a sticky overflow status.

## Interface

Parameters:
- CNTRS_N, 256, number of counters; sets the id width
- CNTRS_W, 32, counter data width
- CNTRS_ID_W, $clog2(CNTRS_N), counter id width
- DEPTH, 8, queue entries; power of two, minimum 2
- DROP_CNT_W, 16, width of the drop counter

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset; synchronous, active-high
- in_pass  in  1  status beat valid; from the counter pipeline's status pass
- in_qry  in  1  beat is a query response
- in_id  in  CNTRS_ID_W  counter id of the beat
- in_dat  in  CNTRS_W  counter value of the beat
- out_vld  out  1  queue head valid
- out_rdy  in  1  consumer accepts the head
- out_id  out  CNTRS_ID_W  head counter id
- out_dat  out  CNTRS_W  head counter value
- fill_r  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- ovfl_r  out  1  sticky: at least one response was dropped
- ovfl_clr  in  1  clears ovfl_r and the drop counter
- drop_cnt_r  out  DROP_CNT_W  dropped-response count; see Configuration

## Operation

- Push request: push = in_pass & in_qry. Beats with in_pass=1 and in_qry=0 are ignored.
- Pop: pop = out_vld & out_rdy.
- Accept rule: a push is accepted if fill_r < DEPTH, or if fill_r == DEPTH and pop is asserted in the same cycle (the slot freed by the pop is reused).
- Drop: a push that is not accepted is discarded. ovfl_r is set and the drop counter increments.
- Storage:
  - Flop array of DEPTH entries of {id, dat}.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked in fill_r, not derived from the pointers.
- fill_r update: next = fill_r + accepted_push - pop.
  - Simultaneous accepted push and pop leave fill_r unchanged.
  - fill_r never exceeds DEPTH and never goes below 0.
- Outputs:
  - out_vld = (fill_r != 0).
  - out_id/out_dat = entry at the read pointer when out_vld=1; forced to 0 when out_vld=0.
  - Head is stable while out_vld=1 and out_rdy=0.
- No input-to-output combinational path: a beat pushed into an empty queue is not visible on the same cycle.
- Overflow/clear precedence: if ovfl_clr and a drop occur in the same cycle, the drop wins. ovfl_r = 1 and the drop counter = 1.
- Ordering: strict FIFO. Responses leave in arrival order, which is the counter pipeline's issue order.
- Reset: pointers, fill_r, ovfl_r and drop_cnt_r all go to 0, and out_vld goes to 0.
  - Queue contents are discarded; array storage itself is not reset.
  - Reset mid-traffic drops all queued entries with no overflow indication.
  - Pushes in the reset cycle are ignored.

## Timing

- Push-to-visible latency is 1 cycle: a beat accepted at edge N gives out_vld=1 with that entry from edge N onward (when the queue was empty).
- Throughput is one push and one pop per cycle, sustained.
- The full-with-pop case accepts at full rate, with no bubble.
- fill_r, ovfl_r and drop_cnt_r are registered and update at the same edge as the push/pop they reflect.
- Reset values of every output: out_vld=0, out_id=0, out_dat=0, fill_r=0, ovfl_r=0, drop_cnt_r=0.

## Configuration

- Macro: MULTI_COUNTER_STATUS_Q_DROP_CNT_EN.
- Defined:
  - drop_cnt_r counts dropped responses.
  - The count saturates at 2^DROP_CNT_W-1 and does not wrap.
  - ovfl_clr clears it to 0, with drop-wins precedence as above.
- Undefined:
  - The counter logic is absent and drop_cnt_r is tied to 0.
  - ovfl_r behaviour is unchanged.

## Test plan

- **Basic pass-through.** DEPTH=8, out_rdy=1. Push id=3/dat=0x10, then id=7/dat=0x22 on consecutive cycles. Expect out_vld on the following cycles with {3,0x10} then {7,0x22}, fill_r peaking at 1, and ovfl_r=0.
- **Filter.** in_pass=1 with in_qry=0 for 5 cycles. Expect fill_r=0, out_vld=0 and no overflow.
- **Fill and drop.** out_rdy=0, 10 pushes with dat=0..9. Expect fill_r=8 and ovfl_r=1, with drop_cnt_r=2 when the macro is defined (0 when undefined). Then drain with out_rdy=1: expect exactly dat 0..7 in order.
- **Full with simultaneous push/pop.** Queue full, out_rdy=1, push dat=0xAA each cycle for 4 cycles. Expect fill_r to stay 8, no drops, and 0xAA entries to emerge after the original 8.
- **Clear precedence.** ovfl_clr asserted in the same cycle as a drop. Expect ovfl_r=1 and drop_cnt_r=1. Then ovfl_clr alone: expect both 0.
- **Reset mid-traffic.** 5 entries queued, assert rst for 1 cycle with a push pending. Expect out_vld=0, fill_r=0 and ovfl_r=0 after the edge. A push afterwards appears as the sole entry.
